// File: rtl/text_renderer_if.sv
// Pixel-side bundle for text_renderer: banner/colour inputs, VGA coordinates in,
// lit-pixel result out.
interface text_renderer_if;
    logic [71:0] alphabet;
    logic [7:0]  text_color;
    logic        frame_start;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        de_in;
    logic        blink;
    logic        pixel_on;
    logic [7:0]  pixel_rgb;
    logic        de_out;

    modport master (
        output alphabet, text_color, frame_start, hcount, vcount, de_in, blink,
        input  pixel_on, pixel_rgb, de_out
    );
    modport slave (
        input  alphabet, text_color, frame_start, hcount, vcount, de_in, blink,
        output pixel_on, pixel_rgb, de_out
    );
endinterface

// File: rtl/text_renderer.sv
// 12-character 5x7 banner renderer, two-stage pixel pipeline, per-frame shadowed text.
// Optional TEXT_BLINK_EN: 6-bit frame counter hides the banner 32 of every 64 frames.
module text_renderer #(
    parameter int X0         = 64,
    parameter int Y0         = 32,
    parameter int SCALE_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    text_renderer_if.slave bus
);
    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + (96 << SCALE_LOG2));
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0 + (8 << SCALE_LOG2));
    localparam logic [5:0]  BLANK = 6'd37;

    // Rows 0..6 packed MSB-first, each row bit 4 = leftmost column.
    function automatic logic [34:0] glyph(input logic [5:0] code);
        case (code)
            6'd0:  glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
            6'd1:  glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
            6'd2:  glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
            6'd3:  glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
            6'd4:  glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
            6'd5:  glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
            6'd6:  glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
            6'd7:  glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
            6'd8:  glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
            6'd9:  glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
            6'd10: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
            6'd11: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
            6'd12: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
            6'd13: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
            6'd14: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
            6'd15: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
            6'd16: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
            6'd17: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
            6'd18: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
            6'd19: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
            6'd20: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
            6'd21: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
            6'd22: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
            6'd23: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
            6'd24: glyph = 35'b10001_10001_01010_00100_00100_00100_00100;
            6'd25: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
            6'd26: glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
            6'd27: glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
            6'd28: glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
            6'd29: glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
            6'd30: glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
            6'd31: glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
            6'd32: glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
            6'd33: glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
            6'd34: glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
            6'd35: glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
            6'd36: glyph = 35'b00000_00000_00000_11111_00000_00000_00000;
            default: glyph = 35'd0;
        endcase
    endfunction

    function automatic logic [4:0] glyph_row(input logic [5:0] code, input logic [2:0] row);
        logic [34:0] g;
        g = glyph(code) << (5 * row);
        return (row == 3'd7) ? 5'd0 : g[34:30];
    endfunction

    logic [71:0] sh_alpha_d, sh_alpha_q;
    logic [7:0]  sh_color_d, sh_color_q;
    logic        hide;

    logic        s1_region_d, s1_region_q;
    logic [5:0]  s1_code_d, s1_code_q;
    logic [2:0]  s1_gx_d, s1_gx_q;
    logic [2:0]  s1_gy_d, s1_gy_q;
    logic        s1_de_d, s1_de_q;
    logic [7:0]  s1_color_d, s1_color_q;
    logic        s1_hide_d, s1_hide_q;

    logic        pixel_on_d, pixel_on_q;
    logic [7:0]  pixel_rgb_d, pixel_rgb_q;
    logic        de_out_d, de_out_q;

    logic [11:0] h12, v12, rx, ry;
    logic [3:0]  char_idx;
    logic [5:0]  chars [0:15];
    logic [4:0]  row_bits;
    logic [4:0]  row_shift;

`ifdef TEXT_BLINK_EN
    logic       sh_blink_d, sh_blink_q;
    logic [5:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
        sh_blink_d  = sh_blink_q;
        frame_cnt_d = frame_cnt_q;
        if (bus.frame_start) begin
            sh_blink_d  = bus.blink;
            frame_cnt_d = frame_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_blink_q  <= 1'b0;
            frame_cnt_q <= 6'd0;
        end else begin
            sh_blink_q  <= sh_blink_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hide = sh_blink_q & frame_cnt_q[5];
`else
    logic unused_blink;
    assign unused_blink = bus.blink;
    assign hide = 1'b0;
`endif

    // Shadows only move on frame_start, so the pixel sampled in that same cycle
    // still reads the previous frame's text.
    always_comb begin
        sh_alpha_d = sh_alpha_q;
        sh_color_d = sh_color_q;
        if (bus.frame_start) begin
            sh_alpha_d = bus.alphabet;
            sh_color_d = bus.text_color;
        end
    end

    always_comb begin
        h12 = {2'b00, bus.hcount};
        v12 = {2'b00, bus.vcount};
        rx  = h12 - X_LO;
        ry  = v12 - Y_LO;
        for (int i = 0; i < 16; i++)
            chars[i] = (i < 12) ? sh_alpha_q[71 - 6*i -: 6] : BLANK;
        char_idx    = 4'(rx >> (SCALE_LOG2 + 3));
        s1_region_d = (h12 >= X_LO) && (h12 < X_HI) && (v12 >= Y_LO) && (v12 < Y_HI);
        s1_code_d   = chars[char_idx];
        s1_gx_d     = 3'(rx >> SCALE_LOG2);
        s1_gy_d     = 3'(ry >> SCALE_LOG2);
        s1_de_d     = bus.de_in;
        s1_color_d  = sh_color_q;
        s1_hide_d   = hide;
    end

    always_comb begin
        row_bits    = glyph_row(s1_code_q, s1_gy_q);
        row_shift   = row_bits << s1_gx_q;
        pixel_on_d  = s1_de_q & s1_region_q & (s1_gx_q < 3'd5) & row_shift[4] & ~s1_hide_q;
        pixel_rgb_d = pixel_on_d ? s1_color_q : 8'h00;
        de_out_d    = s1_de_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_alpha_q  <= {12{BLANK}};
            sh_color_q  <= 8'hFF;
            s1_region_q <= 1'b0;
            s1_code_q   <= BLANK;
            s1_gx_q     <= 3'd0;
            s1_gy_q     <= 3'd0;
            s1_de_q     <= 1'b0;
            s1_color_q  <= 8'h00;
            s1_hide_q   <= 1'b0;
            pixel_on_q  <= 1'b0;
            pixel_rgb_q <= 8'h00;
            de_out_q    <= 1'b0;
        end else begin
            sh_alpha_q  <= sh_alpha_d;
            sh_color_q  <= sh_color_d;
            s1_region_q <= s1_region_d;
            s1_code_q   <= s1_code_d;
            s1_gx_q     <= s1_gx_d;
            s1_gy_q     <= s1_gy_d;
            s1_de_q     <= s1_de_d;
            s1_color_q  <= s1_color_d;
            s1_hide_q   <= s1_hide_d;
            pixel_on_q  <= pixel_on_d;
            pixel_rgb_q <= pixel_rgb_d;
            de_out_q    <= de_out_d;
        end
    end

    assign bus.pixel_on  = pixel_on_q;
    assign bus.pixel_rgb = pixel_rgb_q;
    assign bus.de_out    = de_out_q;
endmodule

// File: doc/text_renderer.md
# text_renderer

Pixel-domain consumer of the 72-bit text banner and 8-bit text colour produced by the game-state text decoder. For each incoming VGA coordinate it decides whether that pixel is lit by the 12-character banner, using an internal 5x7 glyph ROM. The output feeds the top-level colour mux ahead of the VGA pins. Banner contents are double-buffered per frame so mid-frame changes never tear.

## Interface
Parameters:
- X0, 64, banner left edge (pixels)
- Y0, 32, banner top edge (pixels)
- SCALE_LOG2, 2, glyph magnification = 1<<SCALE_LOG2 (0..3)

Ports:
- clk  input  1  system clock (pixel rate)
- rst  input  1  reset, asynchronous, active-high
- alphabet  input  72  12 x 6-bit char codes; [71:66] = char 0 (leftmost)
- text_color  input  8  RGB332 colour of lit pixels
- frame_start  input  1  one-cycle pulse at start of vertical blanking
- hcount  input  10  current pixel x
- vcount  input  10  current pixel y
- de_in  input  1  display-enable for hcount/vcount
- blink  input  1  request blinking text (used only with TEXT_BLINK_EN)
- pixel_on  output  1  pixel belongs to a lit glyph dot
- pixel_rgb  output  8  text_color when pixel_on, else 8'h00
- de_out  output  1  de_in delayed to align with pixel_on/pixel_rgb

## Operation
- Code map: 0-25 = A-Z, 26-35 = '0'-'9', 36 = '-', 37 = blank; 38-63 render blank.
- Glyph row word 5 bits, bit 4 = leftmost column; row 7 of every cell is blank.
- Shadow registers sh_alpha[71:0], sh_color[7:0] load from inputs in the cycle frame_start=1; rendering uses only shadow values.
- Cell is (8<<S) wide x (8<<S) tall, S = SCALE_LOG2; glyph occupies columns 0-4, rows 0-6 of cell (unscaled); columns 5-7 spacing.
- Region: X0 <= hcount < X0+(96<<S) and Y0 <= vcount < Y0+(8<<S); outside region pixel_on=0.
- rx=hcount-X0, ry=vcount-Y0; char index = rx>>(S+3) (0..11); gx=(rx>>S)&7; gy=(ry>>S)&7.
- pixel_on = de & in_region & gx<5 & gy<7 & glyph(code,gy)[4-gx].
- Pipeline: stage 1 registers region flag, char code (muxed from sh_alpha), gx, gy, de; stage 2 registers ROM lookup result, pixel_on, pixel_rgb, de_out.
- de_in=0 forces pixel_on=0, pixel_rgb=0 at output regardless of coordinates.

## Timing
- Latency: exactly 2 cycles from hcount/vcount/de_in to pixel_on/pixel_rgb/de_out; one pixel per cycle, no stalls.
- Reset: pixel_on=0, pixel_rgb=0, de_out=0, pipeline regs cleared, sh_alpha={12{6'd37}}, sh_color=8'hFF, frame counter 0.
- frame_start and de_in high in the same cycle: that pixel uses old shadow; new shadow visible from next cycle's input.
- rst asserted mid-line: outputs go to reset values immediately (async); first valid output 2 cycles after rst deasserts.
- alphabet/text_color changes without frame_start have no visible effect.

## Configuration
- TEXT_BLINK_EN defined: 6-bit frame counter increments on every frame_start (wraps 63->0); when blink=1 and counter[5]=1, pixel_on forced 0 (hidden 32 frames of every 64). blink sampled with frame_start into shadow.
- Undefined: blink ignored, no counter, text always shown.

## Test plan
- Reset: hold rst, drive de_in=1 -> pixel_on=0, pixel_rgb=0, de_out=0; after release with no frame_start, all cells blank (code 37).
- Letter 'A' (code 0 in char 0), text_color=8'hE4, frame_start pulse; defaults X0=64,Y0=32,S=2: (h=68,v=32) -> pixel_on=1, pixel_rgb=8'hE4 two cycles later; (h=64,v=32) -> pixel_on=0.
- Latency/alignment: sweep one full line with de_in toggling -> de_out equals de_in delayed exactly 2 cycles; no lit pixel where de_out=0.
- Shadow: change char 0 from 'A' to blank mid-frame -> 'A' still drawn; after next frame_start -> h=68,v=32 gives pixel_on=0.
- Boundaries: h=63, h=448 (X0+384), v=31, v=64 -> pixel_on=0; code 63 anywhere -> pixel_on=0.
- TEXT_BLINK_EN with blink=1: frames 0-31 show 'A' pixel, frames 32-63 pixel_on=0, frame 64 shown again; blink=0 -> always shown.
